// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer: lowest requesting source wins and is driven onto the bus one cycle later.
// Optional multiple-driver detection is compiled in with the BUS_CONTENTION_CHECK_EN macro.
module bus_mux_reg #(
    parameter int  WIDTH = 32,
    parameter int  NSRC  = 32,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SELW-1:0]       bus_sel
`ifdef BUS_CONTENTION_CHECK_EN
    ,
    input  logic                  err_clear,
    output logic                  contention,
    output logic [7:0]            contention_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bus_q, bus_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic              valid_q, valid_d;

    logic              any_s;
    logic [SELW-1:0]   win_idx_s;
    logic [WIDTH-1:0]  win_data_s;

    // Priority encoder: scan downwards so the lowest requesting index is the last one kept.
    always_comb begin
        any_s      = |src_out;
        win_idx_s  = '0;
        win_data_s = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            win_idx_s  = src_out[i] ? SELW'(i) : win_idx_s;
            win_data_s = src_out[i] ? src_data[i*WIDTH +: WIDTH] : win_data_s;
        end
    end

    // Next-state logic: a request loads the bus; no request keeps data and index, only drops valid.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE, DRIVE: begin
                if (any_s) begin
                    state_d = DRIVE;
                    bus_d   = win_data_s;
                    sel_d   = win_idx_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus state registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            bus_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign bus_sel   = sel_q;

`ifdef BUS_CONTENTION_CHECK_EN
    logic       multi_s;
    logic       contention_q, contention_d;
    logic [7:0] cnt_q, cnt_d;

    // More than one request is present when clearing the lowest set bit leaves something behind.
    always_comb begin
        multi_s      = |(src_out & (src_out - NSRC'(1)));
        contention_d = contention_q;
        cnt_d        = cnt_q;
        if (err_clear) begin
            contention_d = multi_s;
            cnt_d        = multi_s ? 8'd1 : 8'd0;
        end else if (multi_s) begin
            contention_d = 1'b1;
            cnt_d        = (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;
        end else begin
            contention_d = contention_q;
            cnt_d        = cnt_q;
        end
    end

    // Contention status registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            contention_q <= 1'b0;
            cnt_q        <= 8'd0;
        end else begin
            contention_q <= contention_d;
            cnt_q        <= cnt_d;
        end
    end

    assign contention     = contention_q;
    assign contention_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: vector table for single-cycle behaviour plus hand sequences
// for reset, IDLE hold, saturation and the NSRC=2/WIDTH=8 instance.
module tb_bus_mux_reg;

    logic          clock;
    logic          clear;
    logic [1023:0] src_data;
    logic [31:0]   src_out;
    logic [31:0]   bus_out;
    logic          bus_valid;
    logic [4:0]    bus_sel;
    logic [31:0]   words [32];

    logic [15:0]   src_data2;
    logic [1:0]    src_out2;
    logic [7:0]    bus_out2;
    logic          bus_valid2;
    logic [0:0]    bus_sel2;

`ifdef BUS_CONTENTION_CHECK_EN
    logic          err_clear;
    logic          contention;
    logic [7:0]    contention_cnt;
    logic          err_clear2;
    logic          contention2;
    logic [7:0]    contention_cnt2;
`endif

    int checks;
    int errors;

    bus_mux_reg #(.WIDTH(32), .NSRC(32)) dut (
        .clock     (clock),
        .clear     (clear),
        .src_data  (src_data),
        .src_out   (src_out),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_sel   (bus_sel)
`ifdef BUS_CONTENTION_CHECK_EN
        ,
        .err_clear      (err_clear),
        .contention     (contention),
        .contention_cnt (contention_cnt)
`endif
    );

    bus_mux_reg #(.WIDTH(8), .NSRC(2)) dut2 (
        .clock     (clock),
        .clear     (clear),
        .src_data  (src_data2),
        .src_out   (src_out2),
        .bus_out   (bus_out2),
        .bus_valid (bus_valid2),
        .bus_sel   (bus_sel2)
`ifdef BUS_CONTENTION_CHECK_EN
        ,
        .err_clear      (err_clear2),
        .contention     (contention2),
        .contention_cnt (contention_cnt2)
`endif
    );

    for (genvar g = 0; g < 32; g++) begin : g_pack
        assign src_data[g*32 +: 32] = words[g];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] src;
        logic [31:0] exp_out;
        logic        exp_valid;
        logic [4:0]  exp_sel;
        logic        exp_cont;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        src_out    = 32'd0;
        src_out2   = 2'b00;
        src_data2  = 16'h0000;
`ifdef BUS_CONTENTION_CHECK_EN
        err_clear  = 1'b0;
        err_clear2 = 1'b0;
`endif
        for (int i = 0; i < 32; i++) words[i] = 32'hC0DE_0000 | 32'(i);
        words[3]  = 32'h0000_0003;
        words[5]  = 32'h0000_00A5;
        words[7]  = 32'h0000_0077;
        words[17] = 32'h0000_1111;
        words[20] = 32'h0000_2020;
        words[31] = 32'hFFFF_FFFF;

        //            src_out                 bus_out         valid sel    cont  cnt
        vecs[0]  = '{32'h0000_0000,          32'h0000_0000, 1'b0, 5'd0,  1'b0, 8'd0};
        vecs[1]  = '{32'h0000_0000,          32'h0000_0000, 1'b0, 5'd0,  1'b0, 8'd0};
        vecs[2]  = '{32'h0000_0020,          32'h0000_00A5, 1'b1, 5'd5,  1'b0, 8'd0};
        vecs[3]  = '{32'h0000_0000,          32'h0000_00A5, 1'b0, 5'd5,  1'b0, 8'd0};
        vecs[4]  = '{32'h0000_0008,          32'h0000_0003, 1'b1, 5'd3,  1'b0, 8'd0};
        vecs[5]  = '{32'h0002_0000,          32'h0000_1111, 1'b1, 5'd17, 1'b0, 8'd0};
        vecs[6]  = '{32'h8000_0000,          32'hFFFF_FFFF, 1'b1, 5'd31, 1'b0, 8'd0};
        vecs[7]  = '{32'h0010_0080,          32'h0000_0077, 1'b1, 5'd7,  1'b1, 8'd1};
        vecs[8]  = '{32'h0000_0000,          32'h0000_0077, 1'b0, 5'd7,  1'b1, 8'd1};
        vecs[9]  = '{32'h0000_0001,          32'hC0DE_0000, 1'b1, 5'd0,  1'b1, 8'd1};
        vecs[10] = '{32'hFFFF_FFFF,          32'hC0DE_0000, 1'b1, 5'd0,  1'b1, 8'd2};
        vecs[11] = '{32'hC000_0000,          32'hC0DE_001E, 1'b1, 5'd30, 1'b1, 8'd3};
        vecs[12] = '{32'h0000_0000,          32'hC0DE_001E, 1'b0, 5'd30, 1'b1, 8'd3};

        // Reset state while clear is held.
        clear = 1'b1;
        #12;
        check("reset_bus_out", bus_out, 32'd0);
        check("reset_valid", 32'(bus_valid), 32'd0);
        check("reset_sel", 32'(bus_sel), 32'd0);
`ifdef BUS_CONTENTION_CHECK_EN
        check("reset_cont", 32'(contention), 32'd0);
        check("reset_cnt", 32'(contention_cnt), 32'd0);
`endif
        clear = 1'b0;
        tick();

        for (int k = 0; k < 13; k++) begin
            src_out = vecs[k].src;
            tick();
            check($sformatf("vec%0d_out", k), bus_out, vecs[k].exp_out);
            check($sformatf("vec%0d_valid", k), 32'(bus_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_sel", k), 32'(bus_sel), 32'(vecs[k].exp_sel));
`ifdef BUS_CONTENTION_CHECK_EN
            check($sformatf("vec%0d_cont", k), 32'(contention), 32'(vecs[k].exp_cont));
            check($sformatf("vec%0d_cnt", k), 32'(contention_cnt), 32'(vecs[k].exp_cnt));
`endif
        end

        // Data changes while idle must not reach the bus.
        words[30] = 32'hDEAD_BEEF;
        tick();
        check("idle_data_ignored", bus_out, 32'hC0DE_001E);

        // Mid-cycle clear during an active transfer dominates immediately.
        src_out = 32'h0000_0020;
        tick();
        check("pre_clear_out", bus_out, 32'h0000_00A5);
        #2;
        clear = 1'b1;
        #1;
        check("midclear_out", bus_out, 32'd0);
        check("midclear_valid", 32'(bus_valid), 32'd0);
        check("midclear_sel", 32'(bus_sel), 32'd0);
        tick();
        check("held_clear_out", bus_out, 32'd0);
        clear   = 1'b0;
        src_out = 32'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("idle%0d_out", c), bus_out, 32'd0);
            check($sformatf("idle%0d_valid", c), 32'(bus_valid), 32'd0);
        end
        src_out = 32'h0000_0020;
        tick();
        check("post_clear_out", bus_out, 32'h0000_00A5);
        check("post_clear_sel", 32'(bus_sel), 32'd5);
        src_out = 32'd0;
        tick();

`ifdef BUS_CONTENTION_CHECK_EN
        // Saturation of the contention counter and err_clear behaviour.
        src_out = 32'h0000_0006;
        for (int c = 0; c < 300; c++) tick();
        check("sat_cnt", 32'(contention_cnt), 32'd255);
        check("sat_cont", 32'(contention), 32'd1);
        check("sat_sel", 32'(bus_sel), 32'd1);
        check("sat_out", bus_out, 32'hC0DE_0001);
        err_clear = 1'b1;
        src_out   = 32'h0000_0010;
        tick();
        check("errclr_cont", 32'(contention), 32'd0);
        check("errclr_cnt", 32'(contention_cnt), 32'd0);
        check("errclr_out", bus_out, 32'hC0DE_0004);
        src_out = 32'h0000_0003;
        tick();
        check("errclr_multi_cont", 32'(contention), 32'd1);
        check("errclr_multi_cnt", 32'(contention_cnt), 32'd1);
        err_clear = 1'b0;
        src_out   = 32'd0;
        tick();
        check("hold_cnt", 32'(contention_cnt), 32'd1);
`endif

        // Narrow instance: NSRC=2, WIDTH=8.
        src_data2 = 16'h5A33;
        src_out2  = 2'b10;
        tick();
        check("n2_out_src1", 32'(bus_out2), 32'h5A);
        check("n2_sel_src1", 32'(bus_sel2), 32'd1);
        check("n2_valid", 32'(bus_valid2), 32'd1);
        src_out2 = 2'b11;
        tick();
        check("n2_prio_out", 32'(bus_out2), 32'h33);
        check("n2_prio_sel", 32'(bus_sel2), 32'd0);
`ifdef BUS_CONTENTION_CHECK_EN
        check("n2_cont", 32'(contention2), 32'd1);
`endif
        src_out2 = 2'b00;
        tick();
        check("n2_hold_out", 32'(bus_out2), 32'h33);
        check("n2_hold_valid", 32'(bus_valid2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
